// File: rtl/led_pkg.sv
// led_pkg: channel state encoding and default fader constants shared by led_fader and its channels.
package led_pkg;
  typedef enum logic [1:0] {OFF, HOLD, DECAY} ch_state_t;
  localparam int DEF_PWM_BITS   = 8;
  localparam int DEF_DECAY_DIV  = 65536;
  localparam int DEF_HOLD_TICKS = 4;
  localparam int DEF_DECAY_STEP = 16;
endpackage

// File: rtl/led_fade_channel.sv
// led_fade_channel: one LED's strike/hold/decay FSM with registered PWM compare.
// LED_FADER_GAMMA_EN selects square-law dimming of the compare level.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS   = DEF_PWM_BITS,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS,
  parameter int DECAY_STEP = DEF_DECAY_STEP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                strike,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                active
);
  localparam int HW = $clog2(HOLD_TICKS + 2);
  localparam logic [PWM_BITS-1:0] FULL = '1;
  ch_state_t state, state_nx;
  logic [PWM_BITS-1:0] level, level_nx, dec, eff;
  logic [HW-1:0] hold, hold_nx, hold_dec;
  logic led_nx;
  assign dec = int'(level) > DECAY_STEP ? level - PWM_BITS'(DECAY_STEP) : '0;
  // saturate at 0 so HOLD_TICKS = 0 still leaves HOLD on the first tick
  assign hold_dec = hold == '0 ? '0 : hold - 1'b1;
  assign active = state != OFF;
`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  assign sq  = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
  assign eff = sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign eff = level;
`endif
  always_comb begin
    state_nx = state;
    level_nx = level;
    hold_nx  = hold;
    if (strike) begin
      state_nx = HOLD;
      level_nx = FULL;
      hold_nx  = HW'(HOLD_TICKS);
    end else if (tick && state == HOLD) begin
      hold_nx  = hold_dec;
      state_nx = hold_dec == '0 ? DECAY : HOLD;
    end else if (tick && state == DECAY) begin
      level_nx = dec;
      state_nx = dec == '0 ? OFF : DECAY;
    end
    led_nx = active && (level == FULL || pwm_cnt < eff);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= OFF;
      level <= '0;
      hold  <= '0;
      led   <= 1'b0;
    end else begin
      state <= state_nx;
      level <= level_nx;
      hold  <= hold_nx;
      led   <= led_nx;
    end
endmodule

// File: rtl/led_fader.sv
// led_fader: NUM_CH strike-triggered LED faders sharing a decay prescaler and PWM counter.
// Define LED_FADER_GAMMA_EN for square-law dimming.
module led_fader
  import led_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int PWM_BITS   = DEF_PWM_BITS,
  parameter int DECAY_DIV  = DEF_DECAY_DIV,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS,
  parameter int DECAY_STEP = DEF_DECAY_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] pulse_in,
  output logic [NUM_CH-1:0] led_out,
  output logic              busy
);
  localparam int PW = DECAY_DIV > 2 ? $clog2(DECAY_DIV) : 1;
  logic [PW-1:0] presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_CH-1:0] active;
  logic tick;
  assign tick = presc == PW'(DECAY_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      presc   <= tick ? '0 : presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      busy    <= |active;
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .HOLD_TICKS(HOLD_TICKS),
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .strike (pulse_in[i]),
      .pwm_cnt(pwm_cnt),
      .led    (led_out[i]),
      .active (active[i])
    );
  end
endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter NUM_CH, default 6: number of LED channels.
REQ-002 Parameter PWM_BITS, default 8: width of the brightness level and the PWM counter.
REQ-003 Parameter DECAY_DIV, default 65536: clock cycles per decay tick; legal range 2 or more.
REQ-004 Parameter HOLD_TICKS, default 4: decay ticks spent at full brightness after a strike.
REQ-005 Parameter DECAY_STEP, default 16: level decrement per decay tick.
REQ-006 Port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 Port pulse_in, input, NUM_CH bits: per-channel strike strobes from the one-hot LED sequencer; any pattern is legal.
REQ-009 Port led_out, output, NUM_CH bits: registered per-channel PWM drive to the LED pins.
REQ-010 Port busy, output, 1 bit: registered; high while any channel is not OFF.

Function
REQ-011 Prescaler: counts 0 to DECAY_DIV-1 and wraps; tick is a one-cycle pulse when the count equals DECAY_DIV-1.
REQ-012 PWM counter: PWM_BITS wide, free-running, shared by all channels, wraps from all-ones to 0.
REQ-013 Each channel has state OFF, HOLD or DECAY; each channel also has a PWM_BITS level register and a hold counter.
REQ-014 Strike (pulse_in[i] high on a clock edge), from any state:
- level := all-ones
- hold counter := HOLD_TICKS
- state := HOLD
REQ-015 HOLD, no strike, tick: hold counter decrements; when it reaches 0, state := DECAY.
REQ-016 HOLD_TICKS = 0: a strike enters HOLD, and the next tick moves the channel to DECAY.
REQ-017 DECAY, no strike, tick:
- level := level - DECAY_STEP, saturating at 0
- when the resulting level is 0, state := OFF
REQ-018 Strike coinciding with a tick: the strike wins; the tick has no effect on that channel.
REQ-019 Strikes on several channels in one cycle: each channel responds independently and identically.
REQ-020 Strike during DECAY or HOLD: restart at full brightness; no accumulation or overflow.
REQ-021 led_out[i] next value:
- 1 when state is not OFF and level is all-ones
- otherwise 1 when state is not OFF and pwm_cnt < effective level
- otherwise 0
REQ-022 led_out is registered: a strike sampled at edge N gives led_out[i] = 1 from edge N+1, since the level is all-ones.
REQ-023 OFF channel: led_out[i] is 0 constantly.
REQ-024 busy is registered one cycle after the channel states, using the same edge alignment as led_out.

Reset
REQ-025 While rst is high:
- prescaler, PWM counter, levels and hold counters = 0
- all channel states = OFF
- led_out = 0, busy = 0
REQ-026 Assertion of rst mid-fade aborts the fade immediately and asynchronously.
REQ-027 Strikes presented while rst is high are ignored.
REQ-028 Operation resumes on the first clock edge after rst deasserts.

Configuration
REQ-029 Macro LED_FADER_GAMMA_EN defined: effective level = (level*level) >> PWM_BITS, giving square-law perceptual dimming; all-ones still forces full on.
REQ-030 Macro LED_FADER_GAMMA_EN undefined: effective level = level (linear); no multiplier is synthesised.

Structure
REQ-031 The shared package led_pkg holds:
- the channel-state enumeration (OFF, HOLD, DECAY)
- default constants for PWM_BITS, DECAY_DIV, HOLD_TICKS and DECAY_STEP
REQ-032 One sub-module, led_fade_channel, holds a single channel's FSM, level, hold counter and output compare.
REQ-033 led_fader generates NUM_CH instances of led_fade_channel and holds the shared prescaler and PWM counter.

Verification
All scenarios use PWM_BITS=4, DECAY_DIV=4, HOLD_TICKS=2, DECAY_STEP=4 unless stated.
REQ-034 Reset behaviour: assert rst with pulse_in=6'h3F -> led_out=0, busy=0 throughout; after release with no strikes -> outputs stay 0.
REQ-035 Single strike and full fade: pulse_in[0] for 1 cycle ->
- led_out[0]=1 continuously for 2 ticks
- level then steps 11, 7, 3, 0
- PWM duty 11/16 at level 11
- OFF and busy=0 one cycle after level reaches 0
REQ-036 Retrigger: re-strike ch0 while in DECAY at level 7 -> level returns to 15 and HOLD restarts for a full 2 ticks.
REQ-037 Strike/tick collision: pulse_in[2] coincident with a tick at level 3 -> level becomes 15, not 0.
REQ-038 Full sweep: drive the one-hot sweep 1,2,4,...,32,...,1 -> trailing fades on every channel, no channel stuck on.
REQ-039 Reset mid-operation and gamma:
- rst asserted mid-DECAY -> led_out drops asynchronously
- with LED_FADER_GAMMA_EN defined, level 8 -> duty 4/16
